mem_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory of the multi-cycle RISC-V core between two requesters.
  - Requester 0 is the core (fetch, load and store).
  - Requester 1 is the program-loader/debug port.
- Sits between the core controller/datapath and the memory. It serialises accesses, inserts wait states for memory latency and returns read data with a ready pulse.
- The core controller stalls its FSM until c_ready is high.

---
 rtl/mem_arbiter_pkg.sv | 9 +
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter_rr_pick2.sv | 18 +
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic REQ_CORE    = 1'b0;
  localparam logic REQ_LOAD    = 1'b1;
  localparam int   MEM_LAT_MAX = 15;
  localparam int   CNT_W       = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the arbiter.
// slave = arbiter view; master = requesters plus memory.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req, c_we, c_ready;
  logic [AW-1:0] c_adr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          l_req, l_we, l_ready;
  logic [AW-1:0] l_adr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, grant_id;

  modport slave (
    input  c_req, c_we, c_adr, c_wdata, l_req, l_we, l_adr, l_wdata, mem_rdata,
    output c_ready, c_rdata, l_ready, l_rdata, mem_en, mem_we, mem_adr, mem_wdata,
           busy, grant_id
  );

  modport master (
    output c_req, c_we, c_adr, c_wdata, l_req, l_we, l_adr, l_wdata, mem_rdata,
    input  c_ready, c_rdata, l_ready, l_rdata, mem_en, mem_we, mem_adr, mem_wdata,
           busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not granted last.
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);
  // Pick the winner from the request pair and the previous grant.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_CORE;
    if (req == 2'b11)  gnt_id = ~last;
    else if (req[1])   gnt_id = REQ_LOAD;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port unified memory between the core (id 0) and the
// loader/debug port (id 1). Each access runs IDLE -> ISSUE -> WAIT x MEM_LAT
// -> RESP; every output comes straight from a register.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT out of range 1..15");
  end

  state_t        state_q;
  logic          last_q, gid_q, we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdata_q, c_rdata_q, l_rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic          mem_en_q, busy_q, c_ready_q, l_ready_q;
  logic          gnt_valid, gnt_id;

  rr_pick2 u_pick (
    .req       ({bus.l_req, bus.c_req}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Access FSM; outputs are set from the state being entered so they are registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= REQ_LOAD;
      gid_q     <= REQ_CORE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      mem_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      c_ready_q <= 1'b0;
      l_ready_q <= 1'b0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      mem_en_q  <= 1'b0;
      c_ready_q <= 1'b0;
      l_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: if (gnt_valid) begin
          gid_q    <= gnt_id;
          last_q   <= gnt_id;
          we_q     <= gnt_id ? bus.l_we    : bus.c_we;
          adr_q    <= gnt_id ? bus.l_adr   : bus.c_adr;
          wdata_q  <= gnt_id ? bus.l_wdata : bus.c_wdata;
          mem_en_q <= 1'b1;
          busy_q   <= 1'b1;
          state_q  <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= CNT_W'(MEM_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: if (cnt_q == '0) begin
          // Read data is captured even on writes; the requester ignores it then.
          if (gid_q == REQ_LOAD) begin
            l_rdata_q <= bus.mem_rdata;
            l_ready_q <= 1'b1;
          end else begin
            c_rdata_q <= bus.mem_rdata;
            c_ready_q <= 1'b1;
          end
          state_q <= RESP;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counter only ever holds values reachable from its load, so it cannot wrap.
  a_cnt_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    cnt_q <= CNT_W'(MEM_LAT - 1));

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_adr   = adr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.c_ready   = c_ready_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.l_ready   = l_ready_q;
  assign bus.l_rdata   = l_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = gid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances with MEM_LAT 1, 3, 2, 15, each with a
// memory model that presents read data only in the cycle MEM_LAT after mem_en.
module tb_mem_arbiter;
  import arb_pkg::*;

  localparam int NL = 4;
  localparam logic [NL-1:0][3:0] LATS = {4'd15, 4'd2, 4'd3, 4'd1};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        c_req [NL], c_we [NL], l_req [NL], l_we [NL];
  logic [31:0] c_adr [NL], c_wdata [NL], l_adr [NL], l_wdata [NL];
  logic        c_ready [NL], l_ready [NL], mem_en [NL], mem_we [NL], busy [NL], gid [NL];
  logic [31:0] c_rdata [NL], l_rdata [NL], mem_adr [NL], mem_wdata [NL];

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : {24'hC0FFEE, a};
  endfunction

  for (genvar i = 0; i < NL; i++) begin : g_ln
    localparam int L = int'(LATS[i]);
    mem_arbiter_if #(.AW(32), .DW(32)) bus ();
    logic [31:0] mem [256];
    logic [31:0] pend_data;
    int          pend_cnt;

    assign bus.c_req = c_req[i];  assign bus.c_we = c_we[i];
    assign bus.c_adr = c_adr[i];  assign bus.c_wdata = c_wdata[i];
    assign bus.l_req = l_req[i];  assign bus.l_we = l_we[i];
    assign bus.l_adr = l_adr[i];  assign bus.l_wdata = l_wdata[i];
    assign bus.mem_rdata = (pend_cnt == 1) ? pend_data : 32'hBAD0_BAD0;
    assign c_ready[i] = bus.c_ready;  assign c_rdata[i] = bus.c_rdata;
    assign l_ready[i] = bus.l_ready;  assign l_rdata[i] = bus.l_rdata;
    assign mem_en[i]  = bus.mem_en;   assign mem_we[i]  = bus.mem_we;
    assign mem_adr[i] = bus.mem_adr;  assign mem_wdata[i] = bus.mem_wdata;
    assign busy[i]    = bus.busy;     assign gid[i]     = bus.grant_id;

    always @(posedge clk) begin
      if (!reset) begin
        for (int j = 0; j < 256; j++) mem[j] <= init_word(j[7:0]);
        pend_cnt  <= 0;
        pend_data <= '0;
      end else if (bus.mem_en) begin
        if (bus.mem_we) mem[bus.mem_adr[7:0]] <= bus.mem_wdata;
        pend_data <= mem[bus.mem_adr[7:0]];
        pend_cnt  <= L;
      end else if (pend_cnt != 0) begin
        pend_cnt <= pend_cnt - 1;
      end
    end

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  typedef struct {
    int          k;
    logic        who;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        scr;
  } vec_t;

  vec_t vt [11];

  // One complete access on lane k; scr scrambles and drops the request mid-access.
  task automatic access(input string name, input vec_t v);
    int n;
    logic seen, en_ok, hold_ok, other_ok;
    int lat, en_cnt;
    logic [31:0] rd;
    n = 0;
    do begin @(negedge clk); n++; end while (busy[v.k] && n < 50);
    chk1({name, " start idle"}, busy[v.k], 1'b0);
    if (v.who) begin
      l_req[v.k] = 1'b1; l_we[v.k] = v.we; l_adr[v.k] = v.adr; l_wdata[v.k] = v.wd;
    end else begin
      c_req[v.k] = 1'b1; c_we[v.k] = v.we; c_adr[v.k] = v.adr; c_wdata[v.k] = v.wd;
    end
    seen = 1'b0; en_ok = 1'b1; hold_ok = 1'b1; other_ok = 1'b1;
    lat = 0; en_cnt = 0; rd = '0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (mem_en[v.k]) begin
        en_cnt++;
        if (c != 1 || mem_we[v.k] !== v.we || mem_wdata[v.k] !== v.wd) en_ok = 1'b0;
      end
      if (mem_adr[v.k] !== v.adr) hold_ok = 1'b0;
      if ((v.who ? c_ready[v.k] : l_ready[v.k]) !== 1'b0) other_ok = 1'b0;
      if ((v.who ? l_ready[v.k] : c_ready[v.k]) === 1'b1) begin
        seen = 1'b1;
        lat  = c;
        rd   = v.who ? l_rdata[v.k] : c_rdata[v.k];
      end
      if (c == 2 && v.scr) begin
        if (v.who) begin
          l_req[v.k] = 1'b0; l_we[v.k] = ~v.we; l_adr[v.k] = ~v.adr; l_wdata[v.k] = ~v.wd;
        end else begin
          c_req[v.k] = 1'b0; c_we[v.k] = ~v.we; c_adr[v.k] = ~v.adr; c_wdata[v.k] = ~v.wd;
        end
      end
    end
    if (v.who) l_req[v.k] = 1'b0; else c_req[v.k] = 1'b0;
    chk({name, " latency"}, lat, v.exp_lat);
    if (v.chk_rd) chk({name, " rdata"}, rd, v.exp_rd);
    chk({name, " mem_en count"}, en_cnt, 1);
    chk1({name, " issue fields"}, en_ok, 1'b1);
    chk1({name, " mem_adr held"}, hold_ok, 1'b1);
    chk1({name, " other ready quiet"}, other_ok, 1'b1);
    @(posedge clk); #1;
    chk1({name, " ready one cycle"}, v.who ? l_ready[v.k] : c_ready[v.k], 1'b0);
    chk1({name, " busy after"}, busy[v.k], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev_c [8];
    logic ev_id [8];
    logic [31:0] ev_rd [8];
    int ne, lat;
    logic idle_ok, both_ok, early_ok;

    vt[0]  = '{0, REQ_CORE, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEAD_BEEF, 3,  1'b0};
    vt[1]  = '{1, REQ_LOAD, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 32'h0,        5,  1'b0};
    vt[2]  = '{1, REQ_CORE, 1'b0, 32'h40, 32'h0,        1'b1, 32'h1234_5678, 5,  1'b0};
    vt[3]  = '{2, REQ_CORE, 1'b0, 32'h05, 32'h0,        1'b1, 32'hC0FF_EE05, 4,  1'b0};
    vt[4]  = '{3, REQ_CORE, 1'b0, 32'h20, 32'h0,        1'b1, 32'hC0FF_EE20, 17, 1'b1};
    vt[5]  = '{0, REQ_LOAD, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEAD_BEEF, 3,  1'b0};
    vt[6]  = '{2, REQ_CORE, 1'b1, 32'h07, 32'hCAFE_F00D, 1'b0, 32'h0,        4,  1'b1};
    vt[7]  = '{2, REQ_LOAD, 1'b0, 32'h07, 32'h0,        1'b1, 32'hCAFE_F00D, 4,  1'b0};
    vt[8]  = '{0, REQ_CORE, 1'b1, 32'h33, 32'h0BAD_CAFE, 1'b0, 32'h0,        3,  1'b0};
    vt[9]  = '{0, REQ_CORE, 1'b0, 32'h33, 32'h0,        1'b1, 32'h0BAD_CAFE, 3,  1'b1};
    vt[10] = '{3, REQ_LOAD, 1'b0, 32'hFF, 32'h0,        1'b1, 32'hC0FF_EEFF, 17, 1'b0};

    for (int k = 0; k < NL; k++) begin
      c_req[k] = 1'b0; c_we[k] = 1'b0; c_adr[k] = '0; c_wdata[k] = '0;
      l_req[k] = 1'b0; l_we[k] = 1'b0; l_adr[k] = '0; l_wdata[k] = '0;
    end

    // Reset values.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NL; k++) begin
      chk($sformatf("reset ctrl lane%0d", k),
          {26'd0, busy[k], mem_en[k], c_ready[k], l_ready[k], gid[k], mem_we[k]}, 32'd0);
      chk($sformatf("reset data lane%0d", k),
          mem_adr[k] | mem_wdata[k] | c_rdata[k] | l_rdata[k], 32'd0);
    end
    @(negedge clk) reset = 1'b1;

    // No requests: stay idle.
    idle_ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      for (int k = 0; k < NL; k++) if (busy[k] !== 1'b0 || mem_en[k] !== 1'b0) idle_ok = 1'b0;
    end
    chk1("idle 20 cycles", idle_ok, 1'b1);

    // Directed single accesses.
    for (int v = 0; v < 11; v++) access($sformatf("vec%0d", v), vt[v]);

    // Both requesters held from reset on lane 0 (MEM_LAT=1).
    reset = 1'b0;
    repeat (2) @(negedge clk);
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_adr[0] = 32'h10; c_wdata[0] = '0;
    l_req[0] = 1'b1; l_we[0] = 1'b0; l_adr[0] = 32'h21; l_wdata[0] = '0;
    @(negedge clk) reset = 1'b1;
    ne = 0; both_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 2) chk1("rr gid first", gid[0], REQ_CORE);
      if (c == 6) chk1("rr gid second", gid[0], REQ_LOAD);
      if (c_ready[0] === 1'b1 && l_ready[0] === 1'b1) both_ok = 1'b0;
      if (c_ready[0] === 1'b1 || l_ready[0] === 1'b1) begin
        if (ne < 8) begin
          ev_c[ne]  = c;
          ev_id[ne] = l_ready[0];
          ev_rd[ne] = l_ready[0] ? l_rdata[0] : c_rdata[0];
        end
        ne++;
      end
    end
    c_req[0] = 1'b0; l_req[0] = 1'b0;
    chk1("rr never both ready", both_ok, 1'b1);
    chk("rr event count", ne, 10);
    for (int e = 0; e < 4 && e < ne; e++) begin
      chk($sformatf("rr ev%0d cycle", e), ev_c[e], 3 + 4 * e);
      chk1($sformatf("rr ev%0d id", e), ev_id[e], e[0]);
      chk($sformatf("rr ev%0d rdata", e), ev_rd[e], e[0] ? 32'hC0FF_EE21 : 32'hDEAD_BEEF);
    end
    repeat (10) @(posedge clk);

    // Reset during WAIT on lane 1 (MEM_LAT=3), request kept pending.
    @(negedge clk);
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_adr[1] = 32'h40;
    @(posedge clk); #1;
    chk1("rstmid issue mem_en", mem_en[1], 1'b1);
    @(posedge clk); #1;
    chk1("rstmid wait busy", busy[1], 1'b1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk1("rstmid busy", busy[1], 1'b0);
    chk1("rstmid mem_en", mem_en[1], 1'b0);
    chk1("rstmid c_ready", c_ready[1], 1'b0);
    chk1("rstmid l_ready", l_ready[1], 1'b0);
    @(negedge clk) reset = 1'b1;
    lat = 0; early_ok = 1'b1;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (l_ready[1] !== 1'b0) early_ok = 1'b0;
      if (c_ready[1] === 1'b1) begin
        lat = c;
        chk("rstmid rdata", c_rdata[1], 32'hC0FF_EE40);
      end
    end
    c_req[1] = 1'b0;
    chk("rstmid restart latency", lat, 5);
    chk1("rstmid loader quiet", early_ok, 1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
